// File: rtl/array_mul_acc_if.sv
// Stream bundle for array_mul_acc: product beats in, one packet sum out.
// slave = the accumulator's view, master = the producer/consumer around it.
interface array_mul_acc_if #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    logic [PROD_W-1:0] prod_in;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ACC_W-1:0]  sum_out;
    logic [CNT_W-1:0]  cnt_out;
    logic              ovf_out;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  prod_in, in_valid, in_last, out_ready,
        output in_ready, sum_out, cnt_out, ovf_out, out_valid
    );

    modport master (
        output prod_in, in_valid, in_last, out_ready,
        input  in_ready, sum_out, cnt_out, ovf_out, out_valid
    );
endinterface

// File: rtl/array_mul_acc.sv
// Packet accumulator for the multiplier product stream; one registered sum per packet.
// Optional ARRAY_MUL_ACC_SAT_EN: clamp the sum on overflow instead of wrapping.
//
// state | meaning
// ACC   | collecting terms of the current packet, in_ready high
// HOLD  | result pending on the output, waiting for out_ready
module array_mul_acc #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16
) (
    input  logic           clk,
    input  logic           rst,
    array_mul_acc_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TERMS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             valid_q;

    logic             in_ready;
    logic             accept;
    logic             first;
    logic             close;
    logic             carry;
    logic             ovf_nxt;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready = (state == ST_ACC) & ~rst;
    assign accept   = bus.in_valid & in_ready;
    assign first    = (cnt == '0);
    assign close    = accept & (bus.in_last | (cnt == CNT_LAST));
    assign cnt_inc  = cnt + CNT_ONE;

    // First beat of a packet starts from zero, so stale acc/ovf never leak across packets.
    always_comb begin
        acc_base = '0;
        if (!first)
            acc_base = acc;
        sum_ext = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_in};
        carry   = sum_ext[ACC_W];
        ovf_nxt = carry | (ovf & ~first);
`ifdef ARRAY_MUL_ACC_SAT_EN
        acc_nxt = ovf_nxt ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_nxt = sum_ext[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_ACC;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc <= acc_nxt;
                        if (close) begin
                            sum_q   <= acc_nxt;
                            cnt_q   <= cnt_inc;
                            ovf_q   <= ovf_nxt;
                            valid_q <= 1'b1;
                            cnt     <= '0;
                            ovf     <= 1'b0;
                            state   <= ST_HOLD;
                        end else begin
                            cnt <= cnt_inc;
                            ovf <= ovf_nxt;
                        end
                    end
                end
                ST_HOLD: begin
                    // in_ready only comes back the cycle after the handshake
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.sum_out   = sum_q;
    assign bus.cnt_out   = cnt_q;
    assign bus.ovf_out   = ovf_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_array_mul_acc.sv
// Directed bench for array_mul_acc: 16-bit and 10-bit accumulator instances share one stimulus.
module tb_array_mul_acc;
    logic clk;
    logic rst;
    logic [7:0] prod;
    logic in_valid;
    logic in_last;
    logic out_ready;

    int passed = 0;
    int total  = 0;

    array_mul_acc_if #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16)) bus_a ();
    array_mul_acc_if #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(16)) bus_b ();

    assign bus_a.prod_in   = prod;
    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_last   = in_last;
    assign bus_a.out_ready = out_ready;
    assign bus_b.prod_in   = prod;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_last   = in_last;
    assign bus_b.out_ready = out_ready;

    array_mul_acc #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    array_mul_acc #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(16)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for in_ready, let it be taken on the next edge.
    task automatic beat(input logic [7:0] v, input logic last);
        int n;
        prod     = v;
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        while (!bus_a.in_ready && n < 50) begin
            step();
            n++;
        end
        check("beat_ready_wait", 32'(bus_a.in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; prod = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_sum", 32'(bus_a.sum_out), 32'd0);
        check("rst_cnt", 32'(bus_a.cnt_out), 32'd0);
        check("rst_ovf", 32'(bus_a.ovf_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("idle_in_ready", 32'(bus_a.in_ready), 32'd1);

        // 225+225+225
        beat(8'd225, 1'b0);
        check("t1_no_valid_early", 32'(bus_a.out_valid), 32'd0);
        beat(8'd225, 1'b0);
        beat(8'd225, 1'b1);
        check("t1_valid", 32'(bus_a.out_valid), 32'd1);
        check("t1_sum", 32'(bus_a.sum_out), 32'd675);
        check("t1_cnt", 32'(bus_a.cnt_out), 32'd3);
        check("t1_ovf", 32'(bus_a.ovf_out), 32'd0);
        check("t1_sum_b", 32'(bus_b.sum_out), 32'd675);
        check("t1_hold_ready", 32'(bus_a.in_ready), 32'd0);
        step();
        check("t1_valid_1cyc", 32'(bus_a.out_valid), 32'd0);
        check("t1_ready_back", 32'(bus_a.in_ready), 32'd1);

        // single beat
        beat(8'd9, 1'b1);
        check("t2_sum", 32'(bus_a.sum_out), 32'd9);
        check("t2_cnt", 32'(bus_a.cnt_out), 32'd1);
        check("t2_ready_low", 32'(bus_a.in_ready), 32'd0);
        step();
        check("t2_ready_high", 32'(bus_a.in_ready), 32'd1);

        // backpressure for 5 cycles with in_valid pulses that must be ignored
        out_ready = 1'b0;
        beat(8'd1, 1'b0);
        beat(8'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_ready", 32'(bus_a.in_ready), 32'd0);
            check("t3_hold_valid", 32'(bus_a.out_valid), 32'd1);
            check("t3_hold_sum", 32'(bus_a.sum_out), 32'd3);
            check("t3_hold_cnt", 32'(bus_a.cnt_out), 32'd2);
            prod = 8'd50; in_valid = 1'b1; in_last = 1'b1;
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("t3_still_held", 32'(bus_a.out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        check("t3_released", 32'(bus_a.out_valid), 32'd0);
        check("t3_ready_next", 32'(bus_a.in_ready), 32'd1);

        // 16 beats, never last -> forced close
        for (int i = 0; i < 15; i++) begin
            beat(8'd225, 1'b0);
            check("t4_no_close", 32'(bus_a.out_valid), 32'd0);
        end
        beat(8'd225, 1'b0);
        check("t4_valid", 32'(bus_a.out_valid), 32'd1);
        check("t4_sum", 32'(bus_a.sum_out), 32'd3600);
        check("t4_cnt", 32'(bus_a.cnt_out), 32'd16);
        check("t4_ovf", 32'(bus_a.ovf_out), 32'd0);
        beat(8'd5, 1'b1);
        check("t4_new_sum", 32'(bus_a.sum_out), 32'd5);
        check("t4_new_cnt", 32'(bus_a.cnt_out), 32'd1);

        // 5x225 = 1125: fits 16 bits, overflows 10 bits
        for (int i = 0; i < 4; i++) beat(8'd225, 1'b0);
        beat(8'd225, 1'b1);
        check("t5_sum_a", 32'(bus_a.sum_out), 32'd1125);
        check("t5_ovf_a", 32'(bus_a.ovf_out), 32'd0);
        check("t5_cnt_b", 32'(bus_b.cnt_out), 32'd5);
`ifdef ARRAY_MUL_ACC_SAT_EN
        check("t5_sum_b_sat", 32'(bus_b.sum_out), 32'd1023);
`else
        check("t5_sum_b_wrap", 32'(bus_b.sum_out), 32'd101);
`endif
        check("t5_ovf_b", 32'(bus_b.ovf_out), 32'd1);
        step();

        // reset mid-packet discards the partial sum
        beat(8'd100, 1'b0);
        beat(8'd100, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 32'(bus_a.in_ready), 32'd0);
        check("t6_rst_sum", 32'(bus_a.sum_out), 32'd0);
        check("t6_rst_cnt", 32'(bus_a.cnt_out), 32'd0);
        check("t6_rst_ovf_b", 32'(bus_b.ovf_out), 32'd0);
        check("t6_rst_valid", 32'(bus_a.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        beat(8'd7, 1'b1);
        check("t6_sum", 32'(bus_a.sum_out), 32'd7);
        check("t6_cnt", 32'(bus_a.cnt_out), 32'd1);
        check("t6_valid", 32'(bus_a.out_valid), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
